// File: rtl/raster_pixel_tx_if.sv
// Load port, pixel stream and status bundle for raster_pixel_tx.
// master is the transmitter side, slave is the frame producer / stream consumer side.
interface raster_pixel_tx_if #(
  parameter int PIX_W = 8
);
  logic             load_valid;
  logic [PIX_W-1:0] load_data;
  logic             load_ready;
  logic             load_restart;
  logic             start;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;
  logic             m_border;
  logic             frame_loaded;
  logic             busy;
  logic             done;

  modport master (
    input  load_valid, load_data, load_restart, start, m_ready,
    output load_ready, m_valid, m_data, m_sof, m_eol, m_eof, m_border,
           frame_loaded, busy, done
  );

  modport slave (
    output load_valid, load_data, load_restart, start, m_ready,
    input  load_ready, m_valid, m_data, m_sof, m_eol, m_eof, m_border,
           frame_loaded, busy, done
  );
endinterface

// File: rtl/raster_pixel_tx.sv
// Frame store loaded sequentially, then streamed in raster order with SOF/EOL/EOF/border markers.
// FETCH primes the read register; each handshake prefetches the next address, so 1 pixel/clk under m_ready=1.
module raster_pixel_tx #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8
) (
  input logic               clk,
  input logic               rst,
  raster_pixel_tx_if.master bus
);

  localparam int NPIX = ROWS * COLS;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LOADED,
    S_FETCH,
    S_STREAM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [PIX_W-1:0] pix_q;

  logic [PIX_W-1:0] mem [NPIX];

  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             last_pix;
  logic             row_edge;
  logic             col_edge;

  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign row_edge = (row_q == '0) || (row_q == ROW_LAST);
  assign col_edge = (col_q == '0) || (col_q == COL_LAST);

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    addr_d   = addr_q;
    row_d    = row_q;
    col_d    = col_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = addr_q;

    unique case (state_q)
      S_LOAD: begin
        if (bus.load_valid) begin
          wr_en = 1'b1;
          if (ld_cnt_q == ADDR_LAST) begin
            ld_cnt_d = '0;
            state_d  = S_LOADED;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      S_LOADED: begin
        // Restart takes priority over start when both arrive together.
        if (bus.load_restart) begin
          ld_cnt_d = '0;
          state_d  = S_LOAD;
        end else if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = S_STREAM;
      end

      S_STREAM: begin
        if (bus.m_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = addr_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_LOADED;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      ld_cnt_q <= '0;
      addr_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      if (rd_en) begin
        pix_q <= mem[rd_addr];
      end
    end
  end

  // Store has no reset; its contents are only meaningful once a frame is loaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ld_cnt_q] <= bus.load_data;
    end
  end

  assign bus.load_ready   = (state_q == S_LOAD);
  assign bus.frame_loaded = (state_q != S_LOAD);
  assign bus.m_valid      = (state_q == S_STREAM);
  assign bus.m_data       = pix_q;
  assign bus.busy         = (state_q == S_FETCH) || (state_q == S_STREAM);
  assign bus.done         = (state_q == S_DONE);

  assign bus.m_sof    = bus.m_valid && (row_q == '0) && (col_q == '0);
  assign bus.m_eol    = bus.m_valid && (col_q == COL_LAST);
  assign bus.m_eof    = bus.m_valid && last_pix;
  assign bus.m_border = bus.m_valid && (row_edge || col_edge);

endmodule
